// File: rtl/encode8x3_arb.sv
// Sequential 8-to-3 encoder/arbiter: registered one-hot grant plus encoded index, held until ack.
// Define ENCODE8X3_RR_EN for round-robin search from a rotating pointer; otherwise fixed priority (lowest index wins).
module encode8x3_arb #(
    parameter logic [2:0] RESET_PTR = 3'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [2:0] sel,
    output logic       valid,
    output logic [7:0] grant,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [2:0] next_sel;
    logic [7:0] next_grant;
    logic [2:0] start;
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;

`ifdef ENCODE8X3_RR_EN
    logic [2:0] ptr;
    logic [2:0] next_ptr;

    assign start = ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= RESET_PTR;
        end else begin
            ptr <= next_ptr;
        end
    end

    always_comb begin
        next_ptr = ptr;
        if (state == GRANT && ack) begin
            next_ptr = sel + 3'd1;
        end
    end
`else
    logic unused_reset_ptr;

    assign unused_reset_ptr = ^RESET_PTR;
    assign start            = 3'd0;
`endif

    // Walk offsets from farthest to nearest so the nearest requester from start is what remains.
    always_comb begin
        pick  = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = start + 3'(i);
            if (req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sel   <= 3'd0;
            grant <= 8'h00;
        end else begin
            state <= next_state;
            sel   <= next_sel;
            grant <= next_grant;
        end
    end

    always_comb begin
        next_state = state;
        next_sel   = sel;
        next_grant = grant;
        case (state)
            IDLE: begin
                if (found) begin
                    next_state = GRANT;
                    next_sel   = pick;
                    next_grant = 8'h01 << pick;
                end
            end
            GRANT: begin
                if (ack) begin
                    next_state = IDLE;
                    next_grant = 8'h00;
                end
            end
            default: begin
                next_state = IDLE;
                next_grant = 8'h00;
            end
        endcase
    end

    assign valid = (state == GRANT);
    assign busy  = (state == GRANT);

endmodule

// File: tb/tb_encode8x3_arb.sv
// Self-checking bench for encode8x3_arb: directed scenarios plus randomized traffic against a behavioural arbiter model.
// Build with or without ENCODE8X3_RR_EN; the model follows the same macro.
module tb_encode8x3_arb;

    localparam logic [2:0] TB_RESET_PTR = 3'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       ack;
    logic [2:0] sel;
    logic       valid;
    logic [7:0] grant;
    logic       busy;

    int checks = 0;
    int errors = 0;

    bit m_valid = 1'b0;
    int m_sel   = 0;
    int m_ptr   = int'(TB_RESET_PTR);

    encode8x3_arb #(.RESET_PTR(TB_RESET_PTR)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .ack   (ack),
        .sel   (sel),
        .valid (valid),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // First requester scanning start, start+1, ... modulo 8; -1 if nobody asks.
    function automatic int firstRequester(input logic [7:0] r, input int start_at);
        for (int off = 0; off < 8; off++) begin
            if (r[(start_at + off) % 8]) return (start_at + off) % 8;
        end
        return -1;
    endfunction

    task automatic modelStep(input logic r_reset, input logic [7:0] r_req, input logic r_ack);
        int k;
        int search_from;
`ifdef ENCODE8X3_RR_EN
        search_from = m_ptr;
`else
        search_from = 0;
`endif
        if (r_reset) begin
            m_valid = 1'b0;
            m_sel   = 0;
            m_ptr   = int'(TB_RESET_PTR);
        end else if (!m_valid) begin
            k = firstRequester(r_req, search_from);
            if (k >= 0) begin
                m_valid = 1'b1;
                m_sel   = k;
            end
        end else if (r_ack) begin
            m_valid = 1'b0;
            m_ptr   = (m_sel + 1) % 8;
        end
    endtask

    // One clock: drive inputs on the falling edge, advance the model with the rising edge, compare just after it.
    task automatic applyStimulus(input string tag, input logic r_reset, input logic [7:0] r_req, input logic r_ack);
        logic [7:0] exp_grant;
        @(negedge clk);
        reset = r_reset;
        req   = r_req;
        ack   = r_ack;
        @(posedge clk);
        modelStep(r_reset, r_req, r_ack);
        #1;
        exp_grant = m_valid ? (8'h01 << m_sel) : 8'h00;
        checkOutput({tag, ".sel"}, 32'(sel), 32'(m_sel));
        checkOutput({tag, ".valid"}, 32'(valid), 32'(m_valid));
        checkOutput({tag, ".grant"}, 32'(grant), 32'(exp_grant));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(m_valid));
    endtask

    initial begin
        reset = 1'b1;
        req   = 8'h00;
        ack   = 1'b0;

        $display("[TB] reset with all requests high");
        applyStimulus("reset0", 1'b1, 8'hFF, 1'b0);
        applyStimulus("reset1", 1'b1, 8'hFF, 1'b0);
        checkOutput("reset.valid_const", 32'(valid), 32'd0);

        $display("[TB] single grant held without ack");
        applyStimulus("single", 1'b0, 8'b0010_0000, 1'b0);
        checkOutput("single.sel_const", 32'(sel), 32'd5);
        checkOutput("single.grant_const", 32'(grant), 32'h20);
        for (int i = 0; i < 5; i++) applyStimulus("single_hold", 1'b0, 8'b0010_0000, 1'b0);
        applyStimulus("single_ack", 1'b0, 8'h00, 1'b1);
        checkOutput("single_ack.grant_const", 32'(grant), 32'h00);

        $display("[TB] all channels requesting with continuous ack");
        for (int i = 0; i < 20; i++) applyStimulus("rotate", 1'b0, 8'hFF, 1'b1);
        applyStimulus("rotate_drain", 1'b0, 8'h00, 1'b1);
        applyStimulus("rotate_idle", 1'b0, 8'h00, 1'b0);

        $display("[TB] wrap and skip around channel 6");
        applyStimulus("wrap_g6", 1'b0, 8'b0100_0000, 1'b0);
        checkOutput("wrap_g6.sel_const", 32'(sel), 32'd6);
        applyStimulus("wrap_ack6", 1'b0, 8'h00, 1'b1);
        applyStimulus("wrap_skip", 1'b0, 8'b0100_0001, 1'b0);
        checkOutput("wrap_skip.sel_const", 32'(sel), 32'd0);
        applyStimulus("wrap_ack0", 1'b0, 8'h00, 1'b1);
        applyStimulus("wrap_only6", 1'b0, 8'b0100_0000, 1'b0);
        checkOutput("wrap_only6.sel_const", 32'(sel), 32'd6);
        applyStimulus("wrap_ack6b", 1'b0, 8'h00, 1'b1);

        $display("[TB] dropping the granted request does not cancel the grant");
        applyStimulus("drop_g3", 1'b0, 8'b0000_1000, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("drop_hold", 1'b0, 8'b1111_0111, 1'b0);
        checkOutput("drop.sel_const", 32'(sel), 32'd3);
        checkOutput("drop.valid_const", 32'(valid), 32'd1);
        applyStimulus("drop_ack", 1'b0, 8'h00, 1'b1);
        applyStimulus("ack_in_idle", 1'b0, 8'h00, 1'b1);

        $display("[TB] reset while granted");
        applyStimulus("rst_g", 1'b0, 8'b1000_0000, 1'b0);
        applyStimulus("rst_mid", 1'b1, 8'hFF, 1'b0);
        checkOutput("rst_mid.grant_const", 32'(grant), 32'h00);
        applyStimulus("rst_after", 1'b0, 8'hFF, 1'b0);
        applyStimulus("rst_after_ack", 1'b0, 8'hFF, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            logic       a;
            logic       rs;
            r  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            a  = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 49) == 0);
            applyStimulus("random", rs, r, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/encode8x3_arb.md
Name: encode8x3_arb

Overview:
- Sequential 8-to-3 encoder/arbiter; performs the reverse of the 3x8 decoder.
- Scans 8 request lines and picks one requester.
- Presents the winner as a registered 3-bit index `sel` plus a one-hot `grant`.
- Holds the selection until the consumer acknowledges it.
- Sits in front of a 3x8 decoder or mux so the 8 sources can share one datapath.

Parameters:
- RESET_PTR, 3'd0: channel index the search starts from after reset; range 0..7.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request lines; bit i high means channel i wants service.
- ack  input  1  consumer accepts the current selection; meaningful only while valid=1.
- sel  output  3  registered encoded index of the granted channel.
- valid  output  1  sel/grant hold a live grant.
- grant  output  8  one-hot of sel when valid=1; 8'h00 otherwise.
- busy  output  1  high whenever state is GRANT (identical to valid).

Behaviour:
- Reset: sampled on a clk rising edge while reset=1.
  - state=IDLE, sel=3'd0, valid=0, grant=8'h00, busy=0, ptr=RESET_PTR.
  - Reset overrides everything, including a grant in progress; no ack is required afterwards.
- All outputs are registered; nothing combinational from req or ack reaches the outputs.
- State IDLE:
  - If req==8'h00, remain in IDLE.
  - Otherwise, at the next edge:
    - sel = first index k with req[k]=1, searching ptr, ptr+1, ..., ptr+7 modulo 8 (3-bit wrap, so 7+1=0).
    - valid=1, grant=1<<k, state goes to GRANT.
  - Latency: req asserted at edge n is sampled at edge n, and valid is high after edge n.
- State GRANT:
  - sel, grant and valid are held stable until ack=1 is sampled.
  - Dropping req[sel] while in GRANT does not cancel the grant; the grant stays held until ack.
  - Changes to other req bits have no effect.
  - When ack=1 is sampled at an edge: valid=0, grant=8'h00, ptr=sel+1 (mod 8), state goes to IDLE. sel keeps its last value.
- ack while in IDLE is ignored.
- Throughput: at most one grant per 2 cycles, because there is always a 1-cycle IDLE bubble after each ack.
- Wrap-around: a grant of channel 7 sets ptr to 0.
- Simultaneous ack and new req on the same edge: the new req is not considered until the IDLE cycle that follows.
- All 8 requesting continuously: grants rotate through ptr, ptr+1, ... and each channel is served once per 8 grants.

Optional Feature:
- Macro: ENCODE8X3_RR_EN.
- Defined:
  - Round-robin search starting at ptr, as described above.
  - ptr is updated on each ack.
- Not defined:
  - Fixed priority: the lowest set index wins (search always starts at 0).
  - ptr and RESET_PTR have no effect; the ptr register may be optimised away.
  - All other timing and handshake behaviour is unchanged.

Test Plan:
- Reset check: hold reset=1 for 2 cycles with req=8'hFF → sel=0, valid=0, grant=8'h00, busy=0 after each edge.
- Single grant: release reset, req=8'b0010_0000 → after 1 edge sel=5, valid=1, grant=8'h20; hold ack=0 for 5 cycles → outputs unchanged; pulse ack → valid=0, grant=8'h00.
- Round robin (RR_EN defined), req=8'hFF held, ack pulsed on every valid cycle → sel sequence 0,1,2,...,7,0 with valid low for one cycle between grants.
- Wrap and skip (RR_EN defined):
  - Grant channel 6 and ack it.
  - Then set req=8'b0100_0001 → next sel=0, not 6.
  - Without RR_EN → sel=0 as well.
  - Then with req=8'b0100_0000 → sel=6 in both builds.
- Fixed priority (RR_EN undefined), req=8'hFF with continuous acks → sel=0 every grant.
- Mid-operation events:
  - Drop req[3] while sel=3 is granted → valid stays 1 and sel stays 3 until ack.
  - Assert reset while granted → next edge valid=0, grant=8'h00, and the following search starts from RESET_PTR.
